store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer placed directly upstream of the data memory's single access port.
- Accepts word stores from the core in one cycle and retires them to memory in FIFO order whenever the port is not needed by a load.
- Forwards buffered data to loads that hit an entry, so program order stays correct while stores are still pending.

Parameters:
- ADDR_BUS_WIDTH, 32, byte-address width.
- DATA_BUS_WIDTH, 32, store word width (4 bytes, big-endian byte order at addr..addr+3).
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock, rising-edge state updates.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  core presents a store this cycle.
- st_addr  in  ADDR_BUS_WIDTH  store byte address.
- st_data  in  DATA_BUS_WIDTH  store word.
- st_ready  out  1  buffer can accept a store (= !full).
- ld_valid  in  1  core performs a load this cycle.
- ld_addr  in  ADDR_BUS_WIDTH  load byte address.
- ld_hit  out  1  load fully satisfied from the buffer.
- ld_fwd_data  out  DATA_BUS_WIDTH  forwarded word, valid when ld_hit.
- ld_stall  out  1  load partially overlaps a pending store; core must hold the load.
- mem_busy  in  1  memory port is claimed by a load this cycle.
- mem_addr  out  ADDR_BUS_WIDTH  head entry address.
- mem_write_data  out  DATA_BUS_WIDTH  head entry data.
- mem_write_en  out  1  drain head this cycle.
- count  out  $clog2(DEPTH)+1  occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (async, rst_n=0):
  - Head, tail and count go to 0; all entry valid bits clear. Entry address/data registers need not be reset.
  - Output values: st_ready=1, empty=1, full=0, mem_write_en=0, ld_hit=0, ld_stall=0, count=0.
  - mem_addr and mem_write_data are don't-care.
- Push:
  - Occurs on a rising edge when st_valid && st_ready.
  - Writes entry[tail]; tail increments modulo DEPTH.
  - st_ready is derived from registered state only. A store presented while full is not accepted, even if a drain happens in the same cycle. The core holds it.
- Drain:
  - mem_write_en = !empty && !mem_busy, combinational.
  - mem_addr and mem_write_data always show entry[head].
  - Memory commits on the falling edge. The buffer pops at the following rising edge when mem_write_en was 1: head increments modulo DEPTH and the entry's valid bit clears.
- Latency: a store pushed into an empty buffer is drainable starting the cycle after the push. There is no same-cycle bypass to memory.
- Simultaneous push and pop: count is unchanged; both pointers advance. Wrap-around at DEPTH-1→0 is exercised naturally by continued traffic.
- Forwarding (combinational, evaluated when ld_valid):
  - Compare ld_addr against all valid entries.
  - Exact match: ld_hit=1 and ld_fwd_data = data of the youngest matching entry (closest to tail).
  - Overlap without exact match on any entry: ld_stall=1 and ld_hit=0. Overlap means |ld_addr - entry_addr| < 4.
  - If an exact match exists but a younger partial overlap also exists, then ld_stall=1 and ld_hit=0.
  - ld_stall clears on its own once the offending entries drain.
  - Only entries registered before the current edge participate. A store being pushed in the same cycle is not forwarded.
  - ld_valid=0 forces ld_hit=0 and ld_stall=0.
- Starvation: if mem_busy is held, draining stalls indefinitely. Stores continue to be accepted until full, and forwarding remains correct.
- Reset mid-operation: pending stores are discarded and never reach memory. The mem_write_en in flight is deasserted immediately, asynchronously.

Decomposition:
- A shared package holds WORD_BYTES=4 and the store-entry struct {valid, addr, data}, for reuse by the load path.
- A natural sub-module is store_buffer_match: a purely combinational age-ordered matcher producing hit, stall and the forwarded index.
- Pointer, count and drain logic stay in the top module.

Test Plan:
- Reset then idle → after rst_n rises: empty=1, st_ready=1, mem_write_en=0, count=0.
- Push 0x10←0xDEADBEEF with mem_busy=0 → next cycle mem_write_en=1, mem_addr=0x10, mem_write_data=0xDEADBEEF; cycle after: empty=1, and memory word 0x10 reads 0xDEADBEEF.
- Hold mem_busy=1, push 4 stores (0x0,0x4,0x8,0xC) → full=1, st_ready=0, and a 5th store is held. Release mem_busy → exactly one drain per cycle in order 0x0,0x4,0x8,0xC; the held 5th store is accepted on the first cycle st_ready=1.
- With mem_busy=1, push 0x20←0x11111111 then 0x20←0x22222222; load 0x20 → ld_hit=1, ld_fwd_data=0x22222222, ld_stall=0.
- Pending store at 0x20; load 0x22 → ld_stall=1, ld_hit=0. Drop mem_busy → after the drain, ld_stall=0 and ld_hit=0.
- Fill 3 entries and assert rst_n=0 mid-drain → mem_write_en drops with no edge needed, count=0, and memory contents past the last completed negedge write are unchanged.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer and the load path that reuses its entries.
//   WORD_BYTES    : bytes per stored word
//   store_entry_t : one buffered store {valid, addr, data}
//   store_tag_t   : the address-only view of an entry used for load matching
//   overlaps()    : true when two word accesses share at least one byte
package store_buffer_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned SB_ADDR_W  = 32;
    localparam int unsigned SB_DATA_W  = 32;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } store_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
    } store_tag_t;

    // |a - b| < WORD_BYTES, computed modulo the address space.
    function automatic logic overlaps(input logic [SB_ADDR_W-1:0] a,
                                      input logic [SB_ADDR_W-1:0] b);
        logic [SB_ADDR_W-1:0] diff;
        diff = a - b;
        return (diff < SB_ADDR_W'(WORD_BYTES)) ||
               ((SB_ADDR_W'(0) - diff) < SB_ADDR_W'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core/memory-side bundle of the store buffer.
//   store  : st_valid, st_addr, st_data -> st_ready
//   load   : ld_valid, ld_addr -> ld_hit, ld_fwd_data, ld_stall
//   memory : mem_busy -> mem_addr, mem_write_data, mem_write_en
//   status : count, empty, full
// master = core/memory side, slave = the buffer.
interface store_buffer_if #(
    parameter int unsigned ADDR_BUS_WIDTH = 32,
    parameter int unsigned DATA_BUS_WIDTH = 32,
    parameter int unsigned DEPTH          = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                      st_valid;
    logic [ADDR_BUS_WIDTH-1:0] st_addr;
    logic [DATA_BUS_WIDTH-1:0] st_data;
    logic                      st_ready;
    logic                      ld_valid;
    logic [ADDR_BUS_WIDTH-1:0] ld_addr;
    logic                      ld_hit;
    logic [DATA_BUS_WIDTH-1:0] ld_fwd_data;
    logic                      ld_stall;
    logic                      mem_busy;
    logic [ADDR_BUS_WIDTH-1:0] mem_addr;
    logic [DATA_BUS_WIDTH-1:0] mem_write_data;
    logic                      mem_write_en;
    logic [CNT_W-1:0]          count;
    logic                      empty;
    logic                      full;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_busy,
        input  st_ready, ld_hit, ld_fwd_data, ld_stall, mem_addr, mem_write_data,
               mem_write_en, count, empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_busy,
        output st_ready, ld_hit, ld_fwd_data, ld_stall, mem_addr, mem_write_data,
               mem_write_en, count, empty, full
    );

endinterface

// File: rtl/store_buffer_match.sv
// Combinational age-ordered load matcher.
//   tags     : address/valid view of every entry
//   head     : index of the oldest entry
//   ld_valid : load present; ld_addr its byte address
//   hit      : youngest overlapping entry is an exact match
//   stall    : youngest overlapping entry is only a partial overlap
//   fwd_idx  : index of the youngest overlapping entry
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  store_tag_t                 tags [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic                       ld_valid,
    input  logic [SB_ADDR_W-1:0]       ld_addr,
    output logic                       hit,
    output logic                       stall,
    output logic [$clog2(DEPTH)-1:0]   fwd_idx
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             found;
    logic             exact;
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last overlap seen is the youngest one; it alone decides
    // whether the load can be served (a younger partial store hides any older exact match).
    always_comb begin
        found   = 1'b0;
        exact   = 1'b0;
        fwd_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (tags[idx].valid && overlaps(ld_addr, tags[idx].addr)) begin
                found   = 1'b1;
                exact   = (tags[idx].addr == ld_addr);
                fwd_idx = idx;
            end
        end
        hit   = ld_valid && found && exact;
        stall = ld_valid && found && !exact;
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of a single-port data memory.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : store_buffer_if.slave (store accept, load forwarding, memory drain, status)
// Stores are retired in FIFO order whenever mem_busy is low; loads that hit a pending
// store are forwarded from the buffer or stalled on partial overlap.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned ADDR_BUS_WIDTH = SB_ADDR_W,
    parameter int unsigned DATA_BUS_WIDTH = SB_DATA_W,
    parameter int unsigned DEPTH          = 4
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [DEPTH-1:0]          valid_q, valid_d;
    logic [ADDR_BUS_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_BUS_WIDTH-1:0] data_q [DEPTH];

    store_entry_t entries [DEPTH];
    store_tag_t   tags    [DEPTH];
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         ld_hit;
    logic         ld_stall;
    logic [PTR_W-1:0] fwd_idx;

    // Occupancy flags come from registered state only, so a drain in the same cycle
    // never lets a store in while full.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.st_valid && !full;
    // Gated by count_q, so an asynchronous reset drops the write enable without an edge.
    assign pop   = !empty && !bus.mem_busy;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries[i].valid = valid_q[i];
            entries[i].addr  = addr_q[i];
            entries[i].data  = data_q[i];
            tags[i].valid    = entries[i].valid;
            tags[i].addr     = entries[i].addr;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        // Push and pop never target the same slot: a push needs !full, a pop needs !empty.
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset; valid_q qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= bus.st_addr;
            data_q[tail_q] <= bus.st_data;
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .tags     (tags),
        .head     (head_q),
        .ld_valid (bus.ld_valid),
        .ld_addr  (bus.ld_addr),
        .hit      (ld_hit),
        .stall    (ld_stall),
        .fwd_idx  (fwd_idx)
    );

    assign bus.st_ready       = !full;
    assign bus.count          = count_q;
    assign bus.empty          = empty;
    assign bus.full           = full;
    assign bus.mem_write_en   = pop;
    assign bus.mem_addr       = entries[head_q].addr;
    assign bus.mem_write_data = entries[head_q].data;
    assign bus.ld_hit         = ld_hit;
    assign bus.ld_stall       = ld_stall;
    assign bus.ld_fwd_data    = entries[fwd_idx].data;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, drain latency, full/back-pressure, forwarding,
// partial-overlap stalls and asynchronous reset mid-drain. A word memory modelled here
// commits writes on the falling edge.
module tb_store_buffer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] mem_model [logic [31:0]];

    store_buffer_if #(
        .ADDR_BUS_WIDTH (32),
        .DATA_BUS_WIDTH (32),
        .DEPTH          (4)
    ) sb ();

    store_buffer #(
        .ADDR_BUS_WIDTH (32),
        .DATA_BUS_WIDTH (32),
        .DEPTH          (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.mem_write_en) mem_model[sb.mem_addr] = sb.mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n          = 1'b0;
        sb.st_valid    = 1'b0;
        sb.st_addr     = '0;
        sb.st_data     = '0;
        sb.ld_valid    = 1'b0;
        sb.ld_addr     = '0;
        sb.mem_busy    = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_empty", 32'(sb.empty), 32'd1);
        chk("rst_st_ready", 32'(sb.st_ready), 32'd1);
        chk("rst_wr_en", 32'(sb.mem_write_en), 32'd0);
        chk("rst_count", 32'(sb.count), 32'd0);
        chk("rst_full", 32'(sb.full), 32'd0);

        // Single store drains the cycle after the push, never in the same cycle
        tick();
        sb.st_valid = 1'b1;
        sb.st_addr  = 32'h10;
        sb.st_data  = 32'hDEADBEEF;
        #1;
        chk("no_bypass_wr_en", 32'(sb.mem_write_en), 32'd0);
        tick();
        sb.st_valid = 1'b0;
        #1;
        chk("drain_wr_en", 32'(sb.mem_write_en), 32'd1);
        chk("drain_addr", sb.mem_addr, 32'h10);
        chk("drain_data", sb.mem_write_data, 32'hDEADBEEF);
        chk("drain_count", 32'(sb.count), 32'd1);
        tick();
        #1;
        chk("drained_empty", 32'(sb.empty), 32'd1);
        chk("drained_wr_en", 32'(sb.mem_write_en), 32'd0);
        chk("mem_0x10", mem_model[32'h10], 32'hDEADBEEF);

        // Fill under mem_busy, hold a 5th store, then drain in order
        sb.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.st_valid = 1'b1;
            sb.st_addr  = 32'(4 * i);
            sb.st_data  = 32'hA0 + 32'(i);
            tick();
        end
        sb.st_addr = 32'h30;
        sb.st_data = 32'h55;
        #1;
        chk("fill_full", 32'(sb.full), 32'd1);
        chk("fill_st_ready", 32'(sb.st_ready), 32'd0);
        chk("fill_count", 32'(sb.count), 32'd4);
        chk("fill_wr_en", 32'(sb.mem_write_en), 32'd0);
        tick();
        sb.mem_busy = 1'b0;
        #1;
        chk("held_count", 32'(sb.count), 32'd4);
        chk("release_st_ready", 32'(sb.st_ready), 32'd0);
        chk("release_wr_en", 32'(sb.mem_write_en), 32'd1);
        chk("order0", sb.mem_addr, 32'h0);
        tick();
        #1;
        chk("order1", sb.mem_addr, 32'h4);
        chk("order1_st_ready", 32'(sb.st_ready), 32'd1);
        chk("order1_count", 32'(sb.count), 32'd3);
        tick();
        sb.st_valid = 1'b0;
        #1;
        chk("order2", sb.mem_addr, 32'h8);
        chk("push_pop_count", 32'(sb.count), 32'd3);
        tick();
        #1;
        chk("order3", sb.mem_addr, 32'hC);
        chk("order3_count", 32'(sb.count), 32'd2);
        tick();
        #1;
        chk("order4_addr", sb.mem_addr, 32'h30);
        chk("order4_data", sb.mem_write_data, 32'h55);
        tick();
        #1;
        chk("fill_drained_empty", 32'(sb.empty), 32'd1);
        chk("mem_0x0", mem_model[32'h0], 32'hA0);
        chk("mem_0xC", mem_model[32'hC], 32'hA3);
        chk("mem_0x30", mem_model[32'h30], 32'h55);

        // Forwarding: youngest exact match wins; same-cycle push is not visible
        sb.mem_busy = 1'b1;
        sb.st_valid = 1'b1;
        sb.st_addr  = 32'h20;
        sb.st_data  = 32'h11111111;
        tick();
        sb.st_data  = 32'h22222222;
        sb.ld_valid = 1'b1;
        sb.ld_addr  = 32'h20;
        #1;
        chk("fwd_old_hit", 32'(sb.ld_hit), 32'd1);
        chk("fwd_old_data", sb.ld_fwd_data, 32'h11111111);
        tick();
        sb.st_valid = 1'b0;
        #1;
        chk("fwd_young_hit", 32'(sb.ld_hit), 32'd1);
        chk("fwd_young_data", sb.ld_fwd_data, 32'h22222222);
        chk("fwd_young_stall", 32'(sb.ld_stall), 32'd0);
        sb.ld_addr = 32'h24;
        #1;
        chk("adjacent_hit", 32'(sb.ld_hit), 32'd0);
        chk("adjacent_stall", 32'(sb.ld_stall), 32'd0);
        sb.ld_addr = 32'h1D;
        #1;
        chk("below_stall", 32'(sb.ld_stall), 32'd1);
        sb.ld_addr = 32'h22;
        #1;
        chk("partial_stall", 32'(sb.ld_stall), 32'd1);
        chk("partial_hit", 32'(sb.ld_hit), 32'd0);
        sb.ld_valid = 1'b0;
        #1;
        chk("no_ld_stall", 32'(sb.ld_stall), 32'd0);
        chk("no_ld_hit", 32'(sb.ld_hit), 32'd0);

        // Younger partial overlap hides an older exact match
        sb.ld_valid = 1'b1;
        sb.ld_addr  = 32'h20;
        sb.st_valid = 1'b1;
        sb.st_addr  = 32'h1E;
        sb.st_data  = 32'h33333333;
        tick();
        sb.st_valid = 1'b0;
        #1;
        chk("younger_partial_stall", 32'(sb.ld_stall), 32'd1);
        chk("younger_partial_hit", 32'(sb.ld_hit), 32'd0);
        chk("starved_count", 32'(sb.count), 32'd3);
        sb.ld_addr  = 32'h22;
        sb.mem_busy = 1'b0;
        #1;
        chk("stall_held", 32'(sb.ld_stall), 32'd1);
        chk("starve_release_addr", sb.mem_addr, 32'h20);
        repeat (3) tick();
        #1;
        chk("stall_cleared", 32'(sb.ld_stall), 32'd0);
        chk("stall_cleared_hit", 32'(sb.ld_hit), 32'd0);
        chk("fwd_drained_empty", 32'(sb.empty), 32'd1);
        chk("mem_0x20", mem_model[32'h20], 32'h22222222);
        chk("mem_0x1E", mem_model[32'h1E], 32'h33333333);

        // Reset in the middle of a drain discards pending stores at once
        sb.ld_valid = 1'b0;
        sb.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.st_valid = 1'b1;
            sb.st_addr  = 32'h40 + 32'(4 * i);
            sb.st_data  = 32'hC0 + 32'(i);
            tick();
        end
        sb.st_valid = 1'b0;
        sb.mem_busy = 1'b0;
        #1;
        chk("pre_rst_wr_en", 32'(sb.mem_write_en), 32'd1);
        chk("pre_rst_addr", sb.mem_addr, 32'h40);
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", 32'(sb.mem_write_en), 32'd0);
        chk("async_rst_count", 32'(sb.count), 32'd0);
        chk("async_rst_empty", 32'(sb.empty), 32'd1);
        repeat (2) tick();
        chk("mem_0x40", mem_model[32'h40], 32'hC0);
        chk("mem_0x44_absent", 32'(mem_model.exists(32'h44)), 32'd0);
        chk("mem_0x48_absent", 32'(mem_model.exists(32'h48)), 32'd0);
        rst_n = 1'b1;
        tick();
        sb.ld_valid = 1'b1;
        sb.ld_addr  = 32'h44;
        #1;
        chk("post_rst_no_hit", 32'(sb.ld_hit), 32'd0);
        chk("post_rst_no_stall", 32'(sb.ld_stall), 32'd0);
        chk("post_rst_wr_en", 32'(sb.mem_write_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
